ber_checker: RTL

Bit-error-rate checker for the convolutional-encoder / channel / Viterbi-decoder link. It sits at the receive end of the test harness. It taps the transmitted information bits (encoder input) and the decoded bits (decoder output), then searches for the decoder's bit latency and locks to it. Once locked it counts compared bits and bit errors, and drops lock when the error density shows it has lost alignment.

---
 rtl/ber_pkg.sv | 10 +
 rtl/ber_checker_if.sv | 39 +++
 rtl/ber_history.sv | 21 ++
 rtl/ber_checker.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// Shared types for the BER checker: lock-state encoding and burst counter width.
package ber_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } ber_state_t;

  localparam int BURST_W = 8;
endpackage

// File: rtl/ber_checker_if.sv
// Tap/status bundle between the link harness (master) and ber_checker (slave).
// Carries max_burst_o only when BER_CHECK_BURST_EN is defined.
interface ber_checker_if #(
  parameter int MAX_LAT = 64,
  parameter int CW      = 16
);
  import ber_pkg::*;

  logic                       ref_valid_i;
  logic                       ref_bit_i;
  logic                       dec_valid_i;
  logic                       dec_bit_i;
  logic                       clear_i;
  ber_state_t                 state_o;
  logic                       locked_o;
  logic [$clog2(MAX_LAT)-1:0] latency_o;
  logic [CW-1:0]              bit_ct_o;
  logic [CW-1:0]              err_ct_o;
  logic                       sat_o;
`ifdef BER_CHECK_BURST_EN
  logic [BURST_W-1:0]         max_burst_o;
`endif

  modport master (
    output ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i, clear_i,
    input  state_o, locked_o, latency_o, bit_ct_o, err_ct_o, sat_o
`ifdef BER_CHECK_BURST_EN
    , input max_burst_o
`endif
  );

  modport slave (
    input  ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i, clear_i,
    output state_o, locked_o, latency_o, bit_ct_o, err_ct_o, sat_o
`ifdef BER_CHECK_BURST_EN
    , output max_burst_o
`endif
  );
endinterface

// File: rtl/ber_history.sv
// Transmitted-bit history: shift register, newest bit at index 0, read port
// returns the bit written rd_idx+1 writes ago (pre-write value).
module ber_history #(
  parameter int MAX_LAT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic                       din,
  input  logic [$clog2(MAX_LAT)-1:0] rd_idx,
  output logic                       rd_bit
);
  logic [MAX_LAT-1:0] hist;

  always_ff @(posedge clk) begin
    if (rst)     hist <= '0;
    else if (we) hist <= {hist[MAX_LAT-2:0], din};
  end

  assign rd_bit = hist[rd_idx];
endmodule

// File: rtl/ber_checker.sv
// Latency-searching bit-error-rate checker for the encoder/Viterbi link.
// Optional longest-error-burst tracking under BER_CHECK_BURST_EN.
module ber_checker
  import ber_pkg::*;
#(
  parameter int MAX_LAT  = 64,
  parameter int LOCK_WIN = 32,
  parameter int LOSS_THR = 8,
  parameter int CW       = 16
) (
  input logic         clk,
  input logic         rst,
  ber_checker_if.slave bus
);
  localparam int LW = $clog2(MAX_LAT);
  localparam int RW = $clog2(LOCK_WIN + 1);
  localparam int EW = $clog2(LOSS_THR + 1);

  ber_state_t    state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [RW-1:0] run_q, run_d, win_cnt_q, win_cnt_d;
  logic [EW-1:0] win_err_q, win_err_d;
  logic [CW-1:0] bit_ct_q, err_ct_q;
  logic          sat_q;
  logic          hist_bit, match, lk_cmp, bit_inc, err_inc;

  ber_history #(.MAX_LAT(MAX_LAT)) u_hist (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.ref_valid_i),
    .din    (bus.ref_bit_i),
    .rd_idx (lat_q),
    .rd_bit (hist_bit)
  );

  assign match  = (bus.dec_bit_i == hist_bit);
  assign lk_cmp = (state_q == LOCKED) && bus.dec_valid_i;

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    run_d     = run_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    bit_inc   = 1'b0;
    err_inc   = 1'b0;
    case (state_q)
      IDLE: if (bus.ref_valid_i) state_d = SEARCH;
      SEARCH: if (bus.dec_valid_i) begin
        if (!match) begin
          run_d = '0;
          lat_d = lat_q + 1'b1;  // MAX_LAT is a power of two, so this wraps
        end else if (run_q == RW'(LOCK_WIN - 1)) begin
          state_d   = LOCKED;
          run_d     = '0;
          win_cnt_d = '0;
          win_err_d = '0;
        end else begin
          run_d = run_q + 1'b1;
        end
      end
      LOCKED: if (lk_cmp) begin
        bit_inc = 1'b1;
        err_inc = !match;
        // loss check wins over the end-of-window clear
        if (!match && win_err_q == EW'(LOSS_THR - 1)) begin
          state_d   = SEARCH;
          run_d     = '0;
          win_cnt_d = '0;
          win_err_d = '0;
        end else if (win_cnt_q == RW'(LOCK_WIN - 1)) begin
          win_cnt_d = '0;
          win_err_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
          win_err_d = win_err_q + EW'(!match);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      run_q     <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      run_q     <= run_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear_i) begin
      bit_ct_q <= '0;
      err_ct_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      if (bit_inc && bit_ct_q != '1) bit_ct_q <= bit_ct_q + 1'b1;
      if (err_inc && err_ct_q != '1) err_ct_q <= err_ct_q + 1'b1;
      if ((bit_inc && bit_ct_q == '1) || (err_inc && err_ct_q == '1)) sat_q <= 1'b1;
    end
  end

`ifdef BER_CHECK_BURST_EN
  logic [BURST_W-1:0] cur_burst_q, max_burst_q, burst_nx;

  assign burst_nx = (cur_burst_q == '1) ? cur_burst_q : cur_burst_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_burst_q <= '0;
      max_burst_q <= '0;
    end else begin
      if (state_d != LOCKED || (lk_cmp && match)) cur_burst_q <= '0;
      else if (lk_cmp)                            cur_burst_q <= burst_nx;
      if (bus.clear_i)                                max_burst_q <= '0;
      else if (err_inc && burst_nx > max_burst_q)     max_burst_q <= burst_nx;
    end
  end

  assign bus.max_burst_o = max_burst_q;
`endif

  assign bus.state_o   = state_q;
  assign bus.locked_o  = (state_q == LOCKED);
  assign bus.latency_o = lat_q;
  assign bus.bit_ct_o  = bit_ct_q;
  assign bus.err_ct_o  = err_ct_q;
  assign bus.sat_o     = sat_q;
endmodule
